// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: instruction-memory request/grant/response channel, decode-side
// valid/ready channel with pre-sliced fields, and the redirect/halt controls from decode.
interface ifu_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;

    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output inst_valid_o, inst_o, pc_o, opcode_o, funct3_o, funct7_o,
        input  inst_ready_i,
        input  redirect_i, redirect_pc_i, halt_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  inst_valid_o, inst_o, pc_o, opcode_o, funct3_o, funct7_o,
        output inst_ready_i,
        output redirect_i, redirect_pc_i, halt_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one word fetch in flight and
// hands each fetched instruction to decode over a valid/ready handshake.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ifu_fetch_if.master bus
);

    // state  | meaning
    // S_REQ  | request presented at pc, waiting for grant
    // S_WAIT | fetch outstanding, waiting for response (dropped if kill set)
    // S_HOLD | instruction valid to decode, held until accepted
    // S_HALT | ebreak seen, no further fetches until reset
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        kill_q, kill_d;
    logic        req;
    logic        valid;
    logic [31:0] redirect_target;

    assign redirect_target = bus.redirect_pc_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        inst_d  = inst_q;
        req     = 1'b0;
        valid   = 1'b0;

        case (state_q)
            S_REQ: begin
                req = 1'b1;
                if (bus.redirect_i) begin
                    pc_d = redirect_target;
                    // A grant in the redirect cycle still leaves a fetch in flight for the old pc.
                    if (bus.imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (bus.halt_i) begin
                    req     = 1'b0;
                    state_d = S_HALT;
                end else if (bus.imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect_i) begin
                    pc_d = redirect_target;
                    if (bus.imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (bus.imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = bus.imem_rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                valid = 1'b1;
                // Redirect wins over acceptance: the held instruction is on the wrong path.
                if (bus.redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (bus.inst_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign bus.imem_req_o   = req & ~rst_i;
    assign bus.imem_addr_o  = pc_q;
    assign bus.inst_valid_o = valid & ~rst_i;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_q;
    assign bus.opcode_o     = inst_q[6:0];
    assign bus.funct3_o     = inst_q[14:12];
    assign bus.funct7_o     = inst_q[31:25];

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed handshake scenarios followed by a randomized run
// against a stream-level model of which (pc, instruction) pairs decode must see.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk_i = 1'b0;
    logic rst_i;
    int   errors = 0;
    int   checks = 0;

    bit   resp_auto = 1'b0;
    int   gnt_pct   = 100;
    int   lat_max   = 0;

    bit          resp_pend, resp_gnt_taken, resp_rv_sent, resp_prev_rst;
    int          resp_cnt;
    logic [31:0] resp_paddr, resp_prev_addr;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: an arbitrary but deterministic word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'hA5A5_0000) * 32'h0001_0DCD) + 32'h0000_1357;
    endfunction

    // Randomized memory: random grant, random response latency, one fetch in flight.
    initial begin
        resp_pend = 0; resp_gnt_taken = 0; resp_rv_sent = 0; resp_prev_rst = 1;
        resp_cnt = 0; resp_paddr = '0; resp_prev_addr = '0;
        forever begin
            @(negedge clk_i);
            #1;
            if (resp_auto) begin
                if (resp_prev_rst) resp_pend = 0;
                else begin
                    if (resp_rv_sent) resp_pend = 0;
                    if (resp_gnt_taken) begin
                        resp_pend  = 1;
                        resp_cnt   = $urandom_range(lat_max, 0);
                        resp_paddr = resp_prev_addr;
                    end
                end
                bus.imem_gnt_i    = 1'b0;
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = $urandom;
                if (resp_pend) begin
                    if (resp_cnt == 0) begin
                        bus.imem_rvalid_i = 1'b1;
                        bus.imem_rdata_i  = mem_word(resp_paddr);
                    end else resp_cnt--;
                end else if (bus.imem_req_o && ($urandom_range(99) < gnt_pct)) begin
                    bus.imem_gnt_i = 1'b1;
                end
                resp_gnt_taken = bus.imem_req_o && bus.imem_gnt_i;
                resp_rv_sent   = bus.imem_rvalid_i;
                resp_prev_addr = bus.imem_addr_o;
                resp_prev_rst  = rst_i;
            end else begin
                resp_pend = 0; resp_gnt_taken = 0; resp_rv_sent = 0; resp_prev_rst = 1;
            end
        end
    end

    task automatic test_reset();
        rst_i = 1'b1;
        bus.imem_gnt_i = 1'b1; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hFFFF_FFFF;
        bus.inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #2;
            checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
            checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid_o); end
        end
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
    endtask

    task automatic test_zero_wait();
        @(negedge clk_i);
        rst_i = 1'b0; bus.imem_gnt_i = 1'b1; bus.inst_ready_i = 1'b1;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL zw_req_c1: got %b want 1", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== RESET_PC) begin errors++; $display("FAIL zw_addr_c1: got %h want %h", bus.imem_addr_o, RESET_PC); end
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0010_0093;
        #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL zw_req_c2: got %b want 0", bus.imem_req_o); end
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL zw_valid_c2: got %b want 0", bus.inst_valid_o); end
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = $urandom;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b1) begin errors++; $display("FAIL zw_valid_c3: got %b want 1", bus.inst_valid_o); end
        checks++; if (bus.pc_o !== RESET_PC) begin errors++; $display("FAIL zw_pc: got %h want %h", bus.pc_o, RESET_PC); end
        checks++; if (bus.inst_o !== 32'h0010_0093) begin errors++; $display("FAIL zw_inst: got %h want 00100093", bus.inst_o); end
        checks++; if (bus.opcode_o !== 7'h13) begin errors++; $display("FAIL zw_opcode: got %h want 13", bus.opcode_o); end
        checks++; if (bus.funct3_o !== 3'd0) begin errors++; $display("FAIL zw_funct3: got %h want 0", bus.funct3_o); end
        checks++; if (bus.funct7_o !== 7'd0) begin errors++; $display("FAIL zw_funct7: got %h want 0", bus.funct7_o); end
        @(negedge clk_i); #2;
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL zw_req_c4: got %b want 1", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 32'h8000_0004) begin errors++; $display("FAIL zw_addr_c4: got %h want 80000004", bus.imem_addr_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        bus.imem_gnt_i = 1'b1; bus.inst_ready_i = 1'b0;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = d;
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = ~d;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            #2;
            checks++; if (bus.inst_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.inst_valid_o); end
            checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %b want 0", i, bus.imem_req_o); end
            checks++; if (bus.pc_o !== 32'h8000_0004) begin errors++; $display("FAIL bp_pc[%0d]: got %h want 80000004", i, bus.pc_o); end
            checks++; if (bus.inst_o !== d) begin errors++; $display("FAIL bp_inst[%0d]: got %h want %h", i, bus.inst_o, d); end
        end
        @(negedge clk_i);
        bus.inst_ready_i = 1'b1;
        @(negedge clk_i);
        bus.inst_ready_i = 1'b0;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL bp_req_after: got %b want 1", bus.imem_req_o); end
        checks++; if (bus.imem_addr_o !== 32'h8000_0008) begin errors++; $display("FAIL bp_addr_after: got %h want 80000008", bus.imem_addr_o); end
    endtask

    task automatic test_redirect_wait();
        bus.imem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0103;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_i);
            bus.redirect_i = (i == 0);
            bus.imem_rvalid_i = (i == 2);
            bus.imem_rdata_i = 32'hDEAD_BEEF;
            #2;
            checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rw_req[%0d]: got %b want 0", i, bus.imem_req_o); end
            checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_valid[%0d]: got %b want 0", i, bus.inst_valid_o); end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            bus.imem_rvalid_i = 1'b0;
            #2;
            checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_valid_after[%0d]: got %b want 0", i, bus.inst_valid_o); end
            checks++; if (bus.imem_addr_o !== 32'h8000_0100 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL rw_addr[%0d]: got req=%b addr=%h want req=1 addr=80000100", i, bus.imem_req_o, bus.imem_addr_o); end
        end
    endtask

    task automatic test_redirect_hold();
        logic [31:0] d, tgt;
        d = $urandom; tgt = $urandom;
        bus.imem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = d;
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = tgt;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h8000_0100 || bus.inst_o !== d) begin errors++; $display("FAIL rh_held: got valid=%b pc=%h inst=%h want 1 80000100 %h", bus.inst_valid_o, bus.pc_o, bus.inst_o, d); end
        @(negedge clk_i);
        bus.redirect_i = 1'b0; bus.inst_ready_i = 1'b0;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rh_dropped: got %b want 0", bus.inst_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== (tgt & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rh_addr: got req=%b addr=%h want 1 %h", bus.imem_req_o, bus.imem_addr_o, tgt & 32'hFFFF_FFFC); end
    endtask

    task automatic test_redirect_req();
        bus.imem_gnt_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0402;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.redirect_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = $urandom;
        #2;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rq_wait: got req=%b valid=%b want 0 0", bus.imem_req_o, bus.inst_valid_o); end
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL rq_killed: got valid=%b want 0", bus.inst_valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8000_0400) begin errors++; $display("FAIL rq_addr: got req=%b addr=%h want 1 80000400", bus.imem_req_o, bus.imem_addr_o); end
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0501;
        @(negedge clk_i);
        bus.redirect_i = 1'b0;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8000_0500) begin errors++; $display("FAIL rq_nogrant: got req=%b addr=%h want 1 80000500", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_halt();
        logic [31:0] d;
        d = $urandom;
        bus.imem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = d;
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b1;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h8000_0500) begin errors++; $display("FAIL ht_accept: got valid=%b pc=%h want 1 80000500", bus.inst_valid_o, bus.pc_o); end
        @(negedge clk_i);
        bus.inst_ready_i = 1'b0; bus.halt_i = 1'b1;
        #2;
        checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL ht_req_halt: got %b want 0", bus.imem_req_o); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            bus.halt_i = 1'b0; bus.redirect_i = (i < 2); bus.redirect_pc_i = 32'h8000_0600; bus.imem_gnt_i = 1'b1;
            #2;
            checks++; if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL ht_stopped[%0d]: got req=%b valid=%b want 0 0", i, bus.imem_req_o, bus.inst_valid_o); end
        end
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RESET_PC) begin errors++; $display("FAIL ht_restart: got req=%b addr=%h want 1 %h", bus.imem_req_o, bus.imem_addr_o, RESET_PC); end
        // Reset while a killed fetch is in flight must clear the kill.
        bus.imem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0700;
        @(negedge clk_i);
        bus.redirect_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = $urandom;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RESET_PC || bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL ht_rst_inflight: got req=%b addr=%h valid=%b want 1 %h 0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, RESET_PC); end
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
        d = $urandom;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = d;
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b0;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== RESET_PC || bus.inst_o !== d) begin errors++; $display("FAIL ht_kill_cleared: got valid=%b pc=%h inst=%h want 1 %h %h", bus.inst_valid_o, bus.pc_o, bus.inst_o, RESET_PC, d); end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] d;
        d = $urandom;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        bus.redirect_i = 1'b0;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_target: got valid=%b req=%b addr=%h want 0 1 fffffffc", bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = d;
        @(negedge clk_i);
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b1;
        #2;
        checks++; if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'hFFFF_FFFC || bus.inst_o !== d) begin errors++; $display("FAIL wr_inst: got valid=%b pc=%h inst=%h want 1 fffffffc %h", bus.inst_valid_o, bus.pc_o, bus.inst_o, d); end
        checks++; if (bus.funct7_o !== d[31:25] || bus.funct3_o !== d[14:12]) begin errors++; $display("FAIL wr_fields: got f7=%h f3=%h want %h %h", bus.funct7_o, bus.funct3_o, d[31:25], d[14:12]); end
        @(negedge clk_i);
        bus.inst_ready_i = 1'b0;
        #2;
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wr_wrap: got req=%b addr=%h want 1 00000000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    // Stream model: decode sees pc = RESET_PC, +4, ... with mem_word(pc); a redirect restarts the stream at the target.
    task automatic test_random();
        logic [31:0] model_pc, exp, tgt;
        int accepts = 0;
        int idle = 0;
        @(negedge clk_i);
        rst_i = 1'b1; bus.redirect_i = 1'b0; bus.halt_i = 1'b0; bus.inst_ready_i = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
        resp_auto = 1'b1; gnt_pct = 60; lat_max = 2;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_pc = RESET_PC;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) begin gnt_pct = $urandom_range(100, 30); lat_max = $urandom_range(3, 0); end
            bus.inst_ready_i = ($urandom_range(99) < 70);
            bus.redirect_i   = ($urandom_range(99) < 6);
            tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            bus.redirect_pc_i = tgt;
            #2;
            if (bus.inst_valid_o) begin
                exp = mem_word(model_pc);
                checks++; if (bus.pc_o !== model_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, bus.pc_o, model_pc); end
                checks++; if (bus.inst_o !== exp) begin errors++; $display("FAIL rnd_inst@%0d: got %h want %h", cyc, bus.inst_o, exp); end
                checks++; if (bus.opcode_o !== exp[6:0] || bus.funct3_o !== exp[14:12] || bus.funct7_o !== exp[31:25]) begin errors++; $display("FAIL rnd_fields@%0d: got %h/%h/%h want %h/%h/%h", cyc, bus.opcode_o, bus.funct3_o, bus.funct7_o, exp[6:0], exp[14:12], exp[31:25]); end
            end
            if (bus.imem_req_o) begin
                checks++; if (bus.imem_addr_o !== model_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.imem_addr_o, model_pc); end
            end
            if (!bus.imem_req_o && !bus.inst_valid_o) idle++;
            else idle = 0;
            if (idle > 8) begin
                checks++; errors++;
                $display("FAIL rnd_stall@%0d: no request or valid for %0d cycles, want at most 8", cyc, idle);
                break;
            end
            if (bus.redirect_i) model_pc = tgt & 32'hFFFF_FFFC;
            else if (bus.inst_valid_o && bus.inst_ready_i) begin
                model_pc = model_pc + 32'd4;
                accepts++;
            end
            @(negedge clk_i);
        end
        bus.redirect_i = 1'b0; bus.inst_ready_i = 1'b0;
        resp_auto = 1'b0;
        checks++; if (accepts < 100) begin errors++; $display("FAIL rnd_progress: got %0d accepted instructions want at least 100", accepts); end
    endtask

    initial begin
        rst_i = 1'b1;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus.inst_ready_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.halt_i = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_halt();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog");
    end
endmodule
